// File: rtl/matrix_addsub_fp32.sv
// Element-wise FP32 matrix add/subtract for DIM x DIM operands.
// One shared add/sub datapath walks the elements one per clock.
module matrix_addsub_fp32 #(
   parameter int DIM = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mode,
   input  logic [32*DIM*DIM-1:0]   matrix_one,
   input  logic [32*DIM*DIM-1:0]   matrix_two,
   output logic [32*DIM*DIM-1:0]   result,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow
);

   localparam int N  = DIM * DIM;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   elem_index;
   logic [32*N-1:0] a_q;
   logic [32*N-1:0] b_q;
   logic            mode_q;

   logic [31:0]     op_a;
   logic [31:0]     op_b;
   logic [31:0]     sum_out;
   logic            sum_ovf;

   // datapath intermediates
   logic            sa, sb, sx, sy;
   logic [7:0]      ea, eb, ex, ey, d;
   logic [22:0]     fa, fb;
   logic            a_nan, b_nan, a_inf, b_inf;
   logic            a_zero, b_zero, swap;
   logic [23:0]     mx, my;
   logic [4:0]      dc;
   logic [53:0]     sh;
   logic [26:0]     my_al;
   logic [27:0]     sum;
   logic [4:0]      lz;
   logic            found;
   logic [25:0]     m;
   logic signed [9:0] e;
   logic            rup;
   logic [32:0]     pk;
   logic signed [9:0] ef;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (elem_index == LAST) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         result     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         elem_index <= '0;
         a_q        <= '0;
         b_q        <= '0;
         mode_q     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q        <= matrix_one;
                  b_q        <= matrix_two;
                  mode_q     <= mode;
                  busy       <= 1'b1;
                  overflow   <= 1'b0;
                  elem_index <= '0;
               end
            end
            RUN: begin
               result[32*elem_index +: 32] <= sum_out;
               overflow   <= overflow | sum_ovf;
               elem_index <= elem_index + 1'b1;
            end
            FIN: begin
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // subtract is add with B's sign flipped
   assign op_a = a_q[32*elem_index +: 32];
   assign op_b = b_q[32*elem_index +: 32] ^ {mode_q, 31'b0};

   always_comb begin
      sum_out = 32'h0;
      sum_ovf = 1'b0;
      {sa, ea, fa} = op_a;
      {sb, eb, fb} = op_b;
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      a_nan  = (ea == 8'hFF) && (fa != 23'h0);
      b_nan  = (eb == 8'hFF) && (fb != 23'h0);
      a_inf  = (ea == 8'hFF) && (fa == 23'h0);
      b_inf  = (eb == 8'hFF) && (fb == 23'h0);

      swap = {eb, fb} > {ea, fa};
      sx   = swap ? sb : sa;
      sy   = swap ? sa : sb;
      ex   = swap ? eb : ea;
      ey   = swap ? ea : eb;
      mx   = {1'b1, swap ? fb : fa};
      my   = {1'b1, swap ? fa : fb};

      // align smaller operand, folding lost bits into sticky
      d     = ex - ey;
      dc    = (d > 8'd31) ? 5'd31 : d[4:0];
      sh    = {my, 3'b000, 27'b0} >> dc;
      my_al = sh[53:27] | {26'b0, |sh[26:0]};

      if (sx ^ sy) sum = {1'b0, mx, 3'b000} - {1'b0, my_al};
      else         sum = {1'b0, mx, 3'b000} + {1'b0, my_al};

      lz    = '0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && sum[i]) begin
            lz    = 5'(26 - i);
            found = 1'b1;
         end
      end

      if (sum[27]) begin
         m = {sum[26:2], sum[1] | sum[0]};
         e = $signed({2'b00, ex}) + 10'sd1;
      end else begin
         m = 26'(sum[26:0] << lz);
         e = $signed({2'b00, ex}) - $signed({5'b0, lz});
      end

      // mantissa carry on round-up ripples into the exponent
      rup = m[2] & (m[3] | m[1] | m[0]);
      pk  = {e, m[25:3]} + {32'b0, rup};
      ef  = $signed(pk[32:23]);

      if (a_nan || b_nan) begin
         sum_out = 32'h7FC00000;
      end else if (a_inf && b_inf) begin
         sum_out = (sa != sb) ? 32'h7FC00000 : op_a;
      end else if (a_inf) begin
         sum_out = op_a;
      end else if (b_inf) begin
         sum_out = op_b;
      end else if (a_zero && b_zero) begin
         sum_out = {sa & sb, 31'b0};
      end else if (a_zero) begin
         sum_out = op_b;
      end else if (b_zero) begin
         sum_out = op_a;
      end else if (sum == 28'h0) begin
         sum_out = 32'h0;
      end else if (ef >= 10'sd255) begin
         sum_out = {sx, 8'hFF, 23'h0};
         sum_ovf = 1'b1;
      end else if (ef <= 10'sd0) begin
         sum_out = 32'h0;
      end else begin
         sum_out = {sx, ef[7:0], pk[22:0]};
      end
   end

endmodule

// File: doc/matrix_addsub_fp32.md
Name: matrix_addsub_fp32

Overview:
- Parametrised successor to the 2x2 FP32 matrix adder.
- Computes R = A + B or R = A - B element-wise for a DIM x DIM matrix of IEEE-754 single-precision values.
- Uses one shared FP32 add/sub datapath that processes one element per cycle, with a start/busy/done handshake.
- Sits in the coprocessor beside the matrix multiplier; its operands and results are flattened buses.

Parameters:
- DIM, 2, matrix dimension (1..8); element count is DIM*DIM.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- mode  in  1  0 = add, 1 = subtract (A - B); latched at start.
- matrix_one  in  32*DIM*DIM  operand A; element (r,c) at bits [32*(r*DIM+c) +: 32].
- matrix_two  in  32*DIM*DIM  operand B; same layout as matrix_one.
- result  out  32*DIM*DIM  result R; same layout.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when all of R is valid.
- overflow  out  1  high if any element overflowed to infinity; valid with done, held until next start.

Behaviour:
- Reset: state = IDLE; result = 0; busy = 0; done = 0; overflow = 0; index = 0. Reset mid-operation aborts it and clears all outputs to the same values.
- FSM states: IDLE, RUN, FIN.
- IDLE -> RUN: on an edge where start = 1. That edge latches matrix_one, matrix_two and mode, sets busy = 1, clears overflow, and sets index = 0.
- RUN: each edge writes result element[index] from the latched operands and increments index.
- RUN -> FIN: taken on the edge that writes element DIM*DIM-1.
- FIN: done = 1 and busy = 0 for exactly one cycle, then return to IDLE.
- Timing: with start sampled at edge t0, element k is written at edge t0+1+k. done is high in the cycle after edge t0+DIM*DIM+1. For DIM=2 that is 5 edges after start.
- start while busy or in FIN is ignored. Changing the operand inputs after start has no effect on the running operation.
- result holds its value between operations. During RUN, result is partially updated and is valid only when done is high.
- Back-to-back: start may be accepted in the IDLE cycle that immediately follows FIN.
- Subtract is implemented as A + (B with its sign bit inverted).
- Datapath (combinational, one element per cycle):
  - Unpack both operands with the hidden bit.
  - Align to the larger exponent, keeping guard, round and sticky bits.
  - Add or subtract the magnitudes, then normalise with a leading-zero shift.
  - Round to nearest, ties to even.
- Special cases:
  - Subnormal inputs are flushed to signed zero before the operation.
  - A result below the minimum normal is flushed to +0.
  - An exact-zero result is +0, except (-0)+(-0), which gives -0.
  - Any NaN input gives canonical 0x7FC00000.
  - inf + (-inf) gives 0x7FC00000.
  - inf with a finite operand gives that inf.
  - Exponent overflow after rounding gives signed inf (0x7F800000 or 0xFF800000) and sets overflow. An inf input alone does not set overflow.

Test Plan:
- DIM=2, mode=0, A=[0x4063D70A, 0x3F800000; 0x3F800000, 0x3F800000], B = all 0x40000000, start -> done 5 edges after start; R=[0x40B1EB85, 0x40400000; 0x40400000, 0x40400000]; overflow=0.
- DIM=2, mode=1, A = all 0x3F800000, B=[0x40000000, 0x3F800000, 0xBF800000, 0x7FC00000] -> R=[0xBF800000, 0x00000000, 0x40000000, 0x7FC00000].
- Rounding and specials:
  - 0x3F800000+0x33800000 -> 0x3F800000 (tie to even).
  - 0x3F800001+0x33800000 -> 0x3F800002.
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000 with overflow=1.
  - 0x7F800000+0xFF800000 -> 0x7FC00000.
  - 0x00400000+0x00000000 -> 0x00000000.
- Handshake: pulse start again during RUN -> ignored; exactly one done pulse; busy high for DIM*DIM+1 cycles. Change inputs mid-run -> R reflects only the latched operands.
- Assert reset at edge t0+2 of a DIM=2 run -> result=0, busy=0, done=0, no done pulse; a fresh start afterwards completes normally.
- DIM=3, mode=0, A element k = k as float (0x00000000, 0x3F800000, …, 0x41000000), B = all 0x3F800000 -> R element k = k+1 as float (0x3F800000 … 0x41100000); done 10 edges after start.
